// File: rtl/r5p_htif_pkg.sv
// Shared types and HTIF command encodings for the tohost monitor.
package r5p_htif_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE,
    TMO
  } r5p_htif_state_t;

  localparam logic [7:0] HTIF_DEV_SYS  = 8'd0;
  localparam logic [7:0] HTIF_DEV_CON  = 8'd1;
  localparam logic [7:0] HTIF_CMD_PUTC = 8'd1;

endpackage

// File: rtl/r5p_htif_fifo.sv
// Small synchronous FIFO with a combinational head so a pushed word is visible the next cycle.
module r5p_htif_fifo #(
  parameter int DAT_W = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DAT_W-1:0] push_dat,
  input  logic             pop,
  output logic [DAT_W-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DAT_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // The extra MSB on each pointer separates the full case from the empty case.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/r5p_htif_monitor.sv
// Passive HTIF tohost snooper: decodes exit and putchar writes on CHN TCB-lite buses,
// buffers console bytes and tracks end-of-test / timeout status.
module r5p_htif_monitor
  import r5p_htif_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter int               CHN        = 1,
  parameter logic [XLEN-1:0]  TOHOST_ADR = 32'h8000_1000,
  parameter int               TIMEOUT    = 20000,
  parameter int               FIFO_DEP   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHN-1:0]           mon_vld,
  input  logic [CHN-1:0]           mon_rdy,
  input  logic [CHN-1:0]           mon_wen,
  input  logic [CHN*XLEN-1:0]      mon_adr,
  input  logic [CHN*XLEN-1:0]      mon_wdt,
  output logic                     con_vld,
  input  logic                     con_rdy,
  output logic [7:0]               con_dat,
  output logic [$clog2(CHN):0]     con_chn,
  output logic                     done,
  output logic                     pass,
  output logic [XLEN-2:0]          code,
  output logic [$clog2(CHN):0]     code_chn,
  output logic                     timeout,
  output logic [15:0]              drop_cnt
);

  localparam int CW    = $clog2(CHN) + 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  r5p_htif_state_t state_reg, state_next;

  logic [CHN-1:0]  exit_hit;
  logic [CHN-1:0]  putc_hit;
  logic [XLEN-1:0] wdt_arr [CHN];

  logic [CW-1:0]   exit_sel;
  logic [XLEN-1:0] exit_wdt;
  logic [CW-1:0]   putc_sel;
  logic [7:0]      putc_byte;
  logic [3:0]      putc_cnt;

  logic            accept;
  logic            exit_any;
  logic            putc_any;
  logic [4:0]      drop_inc;
  logic [16:0]     drop_sum;

  logic [CNT_W-1:0] cnt_reg;
  logic [15:0]      drop_cnt_reg;
  logic [XLEN-2:0]  code_reg;
  logic [CW-1:0]    code_chn_reg;

  logic            fifo_full;
  logic            fifo_empty;
  logic [CW+7:0]   fifo_dat;

  genvar gi;
  generate
    for (gi = 0; gi < CHN; gi++) begin : g_chn
      logic [XLEN-1:0] adr;
      logic [XLEN-1:0] wdt;
      logic            xfer;
      assign adr           = mon_adr[gi*XLEN +: XLEN];
      assign wdt           = mon_wdt[gi*XLEN +: XLEN];
      assign xfer          = mon_vld[gi] & mon_rdy[gi] & mon_wen[gi] & (adr == TOHOST_ADR);
      assign exit_hit[gi]  = xfer & (wdt[31:24] == HTIF_DEV_SYS) & wdt[0];
      assign putc_hit[gi]  = xfer & (wdt[31:24] == HTIF_DEV_CON) & (wdt[23:16] == HTIF_CMD_PUTC);
      assign wdt_arr[gi]   = wdt;
    end
  endgenerate

  // Scanning from the top down leaves the lowest active channel selected.
  always_comb begin
    exit_sel  = '0;
    exit_wdt  = '0;
    putc_sel  = '0;
    putc_byte = '0;
    putc_cnt  = '0;
    for (int i = CHN - 1; i >= 0; i--) begin
      if (exit_hit[i]) begin
        exit_sel = CW'(i);
        exit_wdt = wdt_arr[i];
      end
      if (putc_hit[i]) begin
        putc_sel  = CW'(i);
        putc_byte = wdt_arr[i][7:0];
      end
      putc_cnt = putc_cnt + 4'(putc_hit[i]);
    end
  end

  // Only RUN listens; this still includes the exit cycle itself.
  assign accept   = (state_reg == RUN);
  assign exit_any = accept & (|exit_hit);
  assign putc_any = accept & (|putc_hit);

  // Losers of the priority encode are dropped, plus the winner if the FIFO is full.
  assign drop_inc = putc_any ? (5'(putc_cnt) - 5'd1 + 5'(fifo_full)) : 5'd0;
  assign drop_sum = 17'(drop_cnt_reg) + 17'(drop_inc);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (exit_any) begin
          state_next = DRAIN;
        end else if ((TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1))) begin
          state_next = TMO;
        end
      end
      DRAIN: begin
        if (fifo_empty) state_next = DONE;
      end
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      cnt_reg      <= '0;
      drop_cnt_reg <= '0;
      code_reg     <= '0;
      code_chn_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == RUN) && (TIMEOUT != 0)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (exit_any) begin
        code_reg     <= exit_wdt[XLEN-1:1];
        code_chn_reg <= exit_sel;
      end
    end
  end

  r5p_htif_fifo #(
    .DAT_W (CW + 8),
    .DEPTH (FIFO_DEP)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (putc_any),
    .push_dat ({putc_sel, putc_byte}),
    .pop      (con_rdy),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign con_vld  = ~fifo_empty;
  assign con_chn  = fifo_dat[CW+7:8];
  assign con_dat  = fifo_dat[7:0];
  assign done     = (state_reg == DONE);
  assign timeout  = (state_reg == TMO);
  assign pass     = done & (code_reg == '0);
  assign code     = code_reg;
  assign code_chn = code_chn_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule
